// File: rtl/ay_bus_ctrl_pkg.sv
// Shared definitions for the AY-slot bus front end.
// Holds the AY bus mode encodings, the chip targets and the bus FSM states.
// It also holds the default cycle timings and the config-port threshold,
// plus helpers for mode decode and the per-chip address bit.
package ay_bus_ctrl_pkg;

  localparam int unsigned WR_SETUP_DEF = 3;
  localparam int unsigned WR_PULSE_DEF = 12;
  localparam int unsigned WR_HOLD_DEF  = 3;
  localparam int unsigned RD_SETUP_DEF = 2;
  localparam logic [7:0]  CFG_BASE_DEF = 8'hF8;

  // {bdir, bc2, bc1}
  typedef enum logic [2:0] {
    MODE_INACTIVE = 3'b000,
    MODE_READ     = 3'b011,
    MODE_WRITE    = 3'b110,
    MODE_LATCH    = 3'b111
  } ay_mode_e;

  typedef enum logic [1:0] {
    TGT_YM0,
    TGT_YM1,
    TGT_SAA
  } ay_tgt_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_SETUP,
    ST_W_STROBE,
    ST_W_HOLD,
    ST_R_SETUP,
    ST_R_ACTIVE,
    ST_R_END
  } ay_state_e;

  function automatic ay_mode_e decode_mode(input logic bdir, input logic bc2,
                                           input logic bc1, input logic sel);
    ay_mode_e m;
    m = MODE_INACTIVE;
    if (sel) begin
      case ({bdir, bc2, bc1})
        3'b111:  m = MODE_LATCH;
        3'b110:  m = MODE_WRITE;
        3'b011:  m = MODE_READ;
        default: m = MODE_INACTIVE;
      endcase
    end
    return m;
  endfunction

  // YM: register latch at a0=0, data at a0=1; status read selected by ym_stat.
  function automatic logic ym_a0(input ay_mode_e m, input logic ym_stat);
    logic a0;
    case (m)
      MODE_WRITE: a0 = 1'b1;
      MODE_READ:  a0 = ~ym_stat;
      default:    a0 = 1'b0;
    endcase
    return a0;
  endfunction

  // SAA1099 uses the opposite sense: address latch at a0=1.
  function automatic logic saa_a0(input ay_mode_e m);
    return (m == MODE_LATCH);
  endfunction

endpackage

// File: rtl/ay_bus_ctrl_sync.sv
// Two-flop synchronizer bank for the asynchronous AY bus control pins.
// Ports:
//   clk, rst_n - fclk and asynchronous active-low reset (both stages clear to 0)
//   async_i    - raw asynchronous inputs
//   sync_o     - synchronized outputs, two clocks behind async_i
module ay_bus_ctrl_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/ay_bus_ctrl.sv
// AY-slot bus front end: decodes ZX AY bus cycles and runs timed write/read
// cycles on the local YM2203 #0/#1 and SAA1099 bus. Config-range latches
// raise wr_port instead of accessing a chip.
// Ports:
//   clk, rst_n                        - fclk, asynchronous active-low reset
//   aybc1, aybc2, aybdir, aya8, aya9_n - AY bus control (asynchronous)
//   ayd                               - speccy data bus (driven during reads)
//   d                                 - local chip data bus (driven during writes)
//   wr_port                           - one-clock strobe, config value on ayd
//   yma0, ymcs0_n, ymcs1_n, ymrd_n, ymwr_n - YM2203 control
//   saaa0, saacs_n, saawr_n           - SAA1099 control
//   ym_sel, ym_stat, saa_sel          - routing from cfg
module ay_bus_ctrl
  import ay_bus_ctrl_pkg::*;
#(
  parameter int unsigned WR_SETUP = WR_SETUP_DEF,
  parameter int unsigned WR_PULSE = WR_PULSE_DEF,
  parameter int unsigned WR_HOLD  = WR_HOLD_DEF,
  parameter int unsigned RD_SETUP = RD_SETUP_DEF,
  parameter logic [7:0]  CFG_BASE = CFG_BASE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       aybc1,
  input  logic       aybc2,
  input  logic       aybdir,
  input  logic       aya8,
  input  logic       aya9_n,
  inout  logic [7:0] ayd,
  inout  logic [7:0] d,
  output logic       wr_port,
  output logic       yma0,
  output logic       ymcs0_n,
  output logic       ymcs1_n,
  output logic       ymrd_n,
  output logic       ymwr_n,
  output logic       saaa0,
  output logic       saacs_n,
  output logic       saawr_n,
  input  logic       ym_sel,
  input  logic       ym_stat,
  input  logic       saa_sel
);

  localparam int unsigned MAX_A   = (WR_SETUP > WR_PULSE) ? WR_SETUP : WR_PULSE;
  localparam int unsigned MAX_B   = (WR_HOLD > RD_SETUP) ? WR_HOLD : RD_SETUP;
  localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] WS_LAST = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] WP_LAST = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] WH_LAST = CNT_W'(WR_HOLD - 1);
  localparam logic [CNT_W-1:0] RS_LAST = CNT_W'(RD_SETUP - 1);

  logic [4:0] sync_s;
  ay_bus_ctrl_sync #(.WIDTH(5)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i ({aybdir, aybc2, aybc1, aya8, aya9_n}),
    .sync_o  (sync_s)
  );

  ay_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ay_mode_e         prev_mode_q, mode_now;
  ay_tgt_e          cur_tgt_q, cur_tgt_d, tgt_now, launch_tgt;
  logic [7:0]       dlat_q, dlat_d, launch_dat;
  ay_mode_e         launch_mode;
  logic             pend_valid_q, pend_valid_d;
  ay_mode_e         pend_mode_q, pend_mode_d;
  ay_tgt_e          pend_tgt_q, pend_tgt_d;
  logic [7:0]       pend_dat_q, pend_dat_d;

  logic start, cfg_hit, chip_start, launch_pend, launch_new, launch, queue;
  logic w_st, r_st;

  logic wr_port_q, wr_port_d, yma0_q, yma0_d, saaa0_q, saaa0_d;
  logic ymcs0_n_q, ymcs0_n_d, ymcs1_n_q, ymcs1_n_d, ymrd_n_q, ymrd_n_d;
  logic ymwr_n_q, ymwr_n_d, saacs_n_q, saacs_n_d, saawr_n_q, saawr_n_d;
  logic d_oe_q, d_oe_d, ayd_oe_q, ayd_oe_d;

  always_comb begin
    mode_now = decode_mode(sync_s[4], sync_s[3], sync_s[2], sync_s[1] & ~sync_s[0]);
    tgt_now  = saa_sel ? TGT_SAA : (ym_sel ? TGT_YM1 : TGT_YM0);

    // Only the INACTIVE->active transition starts a cycle.
    start       = (mode_now != MODE_INACTIVE) && (prev_mode_q == MODE_INACTIVE);
    cfg_hit     = start && (mode_now == MODE_LATCH) && (ayd >= CFG_BASE);
    chip_start  = start && !cfg_hit;
    launch_pend = (state_q == ST_IDLE) && pend_valid_q;
    launch_new  = (state_q == ST_IDLE) && !pend_valid_q && chip_start;
    launch      = launch_pend || launch_new;
    // A slot freed by a pending launch this clock may take the new start.
    queue       = chip_start && !launch_new && (mode_now != MODE_READ) &&
                  (!pend_valid_q || launch_pend);

    launch_mode = launch_pend ? pend_mode_q : mode_now;
    launch_tgt  = launch_pend ? pend_tgt_q  : tgt_now;
    launch_dat  = launch_pend ? pend_dat_q  : ayd;

    state_d      = state_q;
    cur_tgt_d    = cur_tgt_q;
    dlat_d       = dlat_q;
    yma0_d       = yma0_q;
    saaa0_d      = saaa0_q;
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    pend_tgt_d   = pend_tgt_q;
    pend_dat_d   = pend_dat_q;
    wr_port_d    = cfg_hit;

    case (state_q)
      ST_IDLE:     if (launch) state_d = (launch_mode == MODE_READ) ? ST_R_SETUP : ST_W_SETUP;
      ST_W_SETUP:  if (cnt_q == WS_LAST) state_d = ST_W_STROBE;
      ST_W_STROBE: if (cnt_q == WP_LAST) state_d = ST_W_HOLD;
      ST_W_HOLD:   if (cnt_q == WH_LAST) state_d = ST_IDLE;
      ST_R_SETUP:  if (cnt_q == RS_LAST) state_d = ST_R_ACTIVE;
      ST_R_ACTIVE: if (mode_now != MODE_READ) state_d = ST_R_END;
      ST_R_END:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Restarts on every state change; free-running wrap elsewhere is unused.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    if (launch) begin
      cur_tgt_d = launch_tgt;
      dlat_d    = launch_dat;
      if (launch_tgt == TGT_SAA) saaa0_d = saa_a0(launch_mode);
      else                       yma0_d  = ym_a0(launch_mode, ym_stat);
    end

    if (launch_pend) pend_valid_d = 1'b0;
    if (queue) begin
      pend_valid_d = 1'b1;
      pend_mode_d  = mode_now;
      pend_tgt_d   = tgt_now;
      pend_dat_d   = ayd;
    end

    // Outputs are registered from the next state so they change on clean edges.
    w_st      = (state_d == ST_W_SETUP) || (state_d == ST_W_STROBE) || (state_d == ST_W_HOLD);
    r_st      = (state_d == ST_R_SETUP) || (state_d == ST_R_ACTIVE) || (state_d == ST_R_END);
    ymcs0_n_d = !((w_st || r_st) && (cur_tgt_d == TGT_YM0));
    ymcs1_n_d = !((w_st || r_st) && (cur_tgt_d == TGT_YM1));
    ymwr_n_d  = !((state_d == ST_W_STROBE) && (cur_tgt_d != TGT_SAA));
    ymrd_n_d  = !((state_d == ST_R_ACTIVE) && (cur_tgt_d != TGT_SAA));
    saacs_n_d = !(w_st && (cur_tgt_d == TGT_SAA));
    saawr_n_d = !((state_d == ST_W_STROBE) && (cur_tgt_d == TGT_SAA));
    d_oe_d    = w_st;
    ayd_oe_d  = (state_d == ST_R_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      prev_mode_q  <= MODE_INACTIVE;
      cur_tgt_q    <= TGT_YM0;
      dlat_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_mode_q  <= MODE_INACTIVE;
      pend_tgt_q   <= TGT_YM0;
      pend_dat_q   <= '0;
      wr_port_q    <= 1'b0;
      yma0_q       <= 1'b0;
      saaa0_q      <= 1'b0;
      ymcs0_n_q    <= 1'b1;
      ymcs1_n_q    <= 1'b1;
      ymrd_n_q     <= 1'b1;
      ymwr_n_q     <= 1'b1;
      saacs_n_q    <= 1'b1;
      saawr_n_q    <= 1'b1;
      d_oe_q       <= 1'b0;
      ayd_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_mode_q  <= mode_now;
      cur_tgt_q    <= cur_tgt_d;
      dlat_q       <= dlat_d;
      pend_valid_q <= pend_valid_d;
      pend_mode_q  <= pend_mode_d;
      pend_tgt_q   <= pend_tgt_d;
      pend_dat_q   <= pend_dat_d;
      wr_port_q    <= wr_port_d;
      yma0_q       <= yma0_d;
      saaa0_q      <= saaa0_d;
      ymcs0_n_q    <= ymcs0_n_d;
      ymcs1_n_q    <= ymcs1_n_d;
      ymrd_n_q     <= ymrd_n_d;
      ymwr_n_q     <= ymwr_n_d;
      saacs_n_q    <= saacs_n_d;
      saawr_n_q    <= saawr_n_d;
      d_oe_q       <= d_oe_d;
      ayd_oe_q     <= ayd_oe_d;
    end
  end

  assign wr_port = wr_port_q;
  assign yma0    = yma0_q;
  assign saaa0   = saaa0_q;
  assign ymcs0_n = ymcs0_n_q;
  assign ymcs1_n = ymcs1_n_q;
  assign ymrd_n  = ymrd_n_q;
  assign ymwr_n  = ymwr_n_q;
  assign saacs_n = saacs_n_q;
  assign saawr_n = saawr_n_q;

  assign d   = d_oe_q ? dlat_q : 'z;
  // SAA1099 cannot be read; the speccy sees an idle bus value instead.
  assign ayd = ayd_oe_q ? ((cur_tgt_q == TGT_SAA) ? 8'hFF : d) : 'z;

endmodule
